// File: rtl/debounce_botoes.sv
// Two-channel button conditioner: sync, debounce and one-shot pulse.
// Ports: clk, rst (sync active-low), btn_enter/btn_reuso raw pins;
//   enter_pulso/reuso_pulso one-cycle pulses, avanco their OR,
//   enter_nivel/reuso_nivel debounced levels (1 = pressed).
module debounce_botoes #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit ATIVO_BAIXO     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_enter,
  input  logic btn_reuso,
  output logic enter_pulso,
  output logic reuso_pulso,
  output logic avanco,
  output logic enter_nivel,
  output logic reuso_nivel
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    SOLTO       = 1'b0,
    PRESSIONADO = 1'b1
  } est_t;

  // index 0 = enter, index 1 = reuso
  logic [1:0]    pino;
  logic [1:0]    s1;
  logic [1:0]    s2;
  logic [1:0]    pronto;
  logic [1:0]    armado;
  logic [1:0]    armado_nx;
  logic [1:0]    pulso_nx;
  est_t          est    [2];
  est_t          est_nx [2];
  logic [CW-1:0] cnt    [2];
  logic [CW-1:0] cnt_nx [2];

  assign pino = {btn_reuso, btn_enter} ^ {2{ATIVO_BAIXO}};

  // pronto marks the synchroniser as refilled after reset, so the
  // reset zeros in s1/s2 are never mistaken for an observed release.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      est_nx[i]    = est[i];
      cnt_nx[i]    = '0;
      pulso_nx[i]  = 1'b0;
      armado_nx[i] = armado[i];
      unique case (est[i])
        SOLTO: begin
          if (s2[i]) begin
            if (cnt[i] == CMAX) begin
              est_nx[i]   = PRESSIONADO;
              pulso_nx[i] = armado[i];
            end else begin
              cnt_nx[i] = cnt[i] + CW'(1);
            end
          end else if (pronto[1]) begin
            armado_nx[i] = 1'b1;
          end
        end
        PRESSIONADO: begin
          if (!s2[i]) begin
            if (cnt[i] == CMAX) begin
              est_nx[i] = SOLTO;
            end else begin
              cnt_nx[i] = cnt[i] + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1          <= '0;
      s2          <= '0;
      pronto      <= '0;
      armado      <= '0;
      enter_pulso <= 1'b0;
      reuso_pulso <= 1'b0;
      avanco      <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        est[i] <= SOLTO;
        cnt[i] <= '0;
      end
    end else begin
      s1          <= pino;
      s2          <= s1;
      pronto      <= {pronto[0], 1'b1};
      armado      <= armado_nx;
      // Reuso wins a tie; the Enter pulse is dropped, not deferred.
      enter_pulso <= pulso_nx[0] & ~pulso_nx[1];
      reuso_pulso <= pulso_nx[1];
      avanco      <= |pulso_nx;
      for (int i = 0; i < 2; i++) begin
        est[i] <= est_nx[i];
        cnt[i] <= cnt_nx[i];
      end
    end
  end

  assign enter_nivel = (est[0] == PRESSIONADO);
  assign reuso_nivel = (est[1] == PRESSIONADO);

endmodule

// File: tb/tb_debounce_botoes.sv
// Bench for debounce_botoes: scoreboard of expected pulses
// popped by a negedge monitor, plus direct level checks.
module tb_debounce_botoes;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_enter = 1'b1;
  logic btn_reuso = 1'b1;
  logic enter_pulso;
  logic reuso_pulso;
  logic avanco;
  logic enter_nivel;
  logic reuso_nivel;

  always #5 clk = ~clk;

  debounce_botoes #(
    .DEBOUNCE_CYCLES(4),
    .ATIVO_BAIXO(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_enter(btn_enter),
    .btn_reuso(btn_reuso),
    .enter_pulso(enter_pulso),
    .reuso_pulso(reuso_pulso),
    .avanco(avanco),
    .enter_nivel(enter_nivel),
    .reuso_nivel(reuso_nivel)
  );

  typedef struct packed {
    logic [31:0] cyc;
    logic [2:0]  v;
  } exp_t;

  int unsigned cyc = 0;
  int total = 0;
  int bad = 0;
  exp_t q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (cyc %0d)",
               nm, got, req, cyc);
    end
  endtask

  // v = {enter_pulso, reuso_pulso, avanco}
  task automatic push(input int d, input logic [2:0] v);
    exp_t e;
    e.cyc = cyc + d;
    e.v   = v;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (enter_pulso | reuso_pulso | avanco) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse",
            {cyc[28:0], enter_pulso, reuso_pulso, avanco}, 32'h0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_value",
            {29'h0, enter_pulso, reuso_pulso, avanco}, {29'h0, e.v});
      end
    end
  end

  function automatic logic [31:0] outs();
    return {27'h0, enter_pulso, reuso_pulso, avanco,
            enter_nivel, reuso_nivel};
  endfunction

  initial begin
    tick(3);
    chk("reset_outputs", outs(), 32'h0);
    rst = 1'b1;
    tick(10);

    // clean press
    btn_enter = 1'b0;
    push(6, 3'b101);
    tick(5);
    chk("clean_level_early", enter_nivel, 1'b0);
    tick(1);
    chk("clean_level", enter_nivel, 1'b1);
    chk("clean_reuso_level", reuso_nivel, 1'b0);
    tick(14);
    btn_enter = 1'b1;
    tick(5);
    chk("clean_release_early", enter_nivel, 1'b1);
    tick(1);
    chk("clean_release", enter_nivel, 1'b0);
    tick(10);

    // bounce on press, then on release
    for (int i = 0; i < 3; i++) begin
      btn_enter = 1'b0;
      tick(2);
      btn_enter = 1'b1;
      tick(2);
    end
    btn_enter = 1'b0;
    push(6, 3'b101);
    tick(5);
    chk("bounce_level_early", enter_nivel, 1'b0);
    tick(1);
    chk("bounce_level", enter_nivel, 1'b1);
    tick(10);
    for (int i = 0; i < 2; i++) begin
      btn_enter = 1'b1;
      tick(3);
      btn_enter = 1'b0;
      tick(3);
    end
    btn_enter = 1'b1;
    tick(5);
    chk("bounce_rel_early", enter_nivel, 1'b1);
    tick(1);
    chk("bounce_rel", enter_nivel, 1'b0);
    tick(10);

    // simultaneous press
    btn_enter = 1'b0;
    btn_reuso = 1'b0;
    push(6, 3'b011);
    tick(6);
    chk("simul_enter_level", enter_nivel, 1'b1);
    chk("simul_reuso_level", reuso_nivel, 1'b1);
    tick(4);
    btn_enter = 1'b1;
    btn_reuso = 1'b1;
    tick(12);

    // held through reset
    btn_reuso = 1'b0;
    push(6, 3'b011);
    tick(10);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("held_reset_outputs", outs(), 32'h0);
    end
    rst = 1'b1;
    tick(20);
    chk("held_level", reuso_nivel, 1'b1);
    btn_reuso = 1'b1;
    tick(12);
    chk("held_released", reuso_nivel, 1'b0);
    btn_reuso = 1'b0;
    push(6, 3'b011);
    tick(12);
    btn_reuso = 1'b1;
    tick(12);

    // reset mid-count
    btn_enter = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("midcount_reset", outs(), 32'h0);
    rst = 1'b1;
    tick(20);
    chk("midcount_level", enter_nivel, 1'b1);
    btn_enter = 1'b1;
    tick(12);
    btn_enter = 1'b0;
    push(6, 3'b101);
    tick(12);
    btn_enter = 1'b1;
    tick(12);

    // long hold
    btn_reuso = 1'b0;
    push(6, 3'b011);
    tick(1000);
    chk("long_level", reuso_nivel, 1'b1);
    btn_reuso = 1'b1;
    tick(12);

    chk("queue_empty", q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
